// File: rtl/rtc_field_editor.sv
// Cursor-driven per-field delta editor. On commit, every field with a non-zero
// delta is read, adjusted by its delta and written back through a handshake port.
module rtc_field_editor #(
    parameter int               NF       = 16,
    parameter int               DW       = 8,
    parameter int               AW       = 8,
    parameter logic [NF*AW-1:0] ADDR_MAP = '0,
    localparam int              IW       = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          en,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic [IW-1:0] win_lo,
    input  logic [IW-1:0] win_hi,
    input  logic          commit,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    input  logic          rd_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          wr_ack,
    output logic [IW-1:0] cursor,
    output logic          busy,
    output logic          done
);

    localparam int KW = $clog2(NF + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DMIN = -DMAX;

    logic [2:0]             r_state;
    logic [KW-1:0]          r_k;
    logic [IW-1:0]          r_cursor;
    logic signed [DW-1:0]   r_delta [NF];
    logic                   r_rd_en;
    logic                   r_wr_en;
    logic                   r_done;
    logic [AW-1:0]          r_rd_addr;
    logic [AW-1:0]          r_wr_addr;
    logic [DW-1:0]          r_wr_data;

    logic [IW-1:0]          w_hi_eff;
    logic [IW-1:0]          w_cursor_nxt;
    logic [IW-1:0]          w_kidx;
    logic                   w_outside;
    logic                   w_busy;
    logic                   w_edit;
    logic [AW-1:0]          w_kaddr;
    logic signed [DW-1:0]   w_cur_delta;
    logic signed [DW-1:0]   w_k_delta;

    assign w_busy      = (r_state != S_IDLE);
    assign w_edit      = en && !w_busy;
    // An inverted window collapses to the single field win_lo
    assign w_hi_eff    = (win_lo > win_hi) ? win_lo : win_hi;
    assign w_outside   = (r_cursor < win_lo) || (r_cursor > w_hi_eff) || (32'(win_hi) >= NF);
    assign w_kidx      = r_k[IW-1:0];
    assign w_kaddr     = ADDR_MAP[w_kidx*AW +: AW];
    assign w_cur_delta = r_delta[r_cursor];
    assign w_k_delta   = r_delta[w_kidx];

    always_comb begin
        w_cursor_nxt = r_cursor;
        if (en) begin
            if (w_outside) begin
                w_cursor_nxt = win_lo;
            end else if (!w_busy) begin
                if (btn_right)
                    w_cursor_nxt = (r_cursor == w_hi_eff) ? win_lo : r_cursor + IW'(1);
                else if (btn_left)
                    w_cursor_nxt = (r_cursor == win_lo) ? w_hi_eff : r_cursor - IW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_cursor  <= '0;
            r_delta   <= '{default: '0};
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_cursor <= w_cursor_nxt;
            if (w_edit && (32'(r_cursor) < NF)) begin
                if (btn_up) begin
                    if (w_cur_delta != DMAX) r_delta[r_cursor] <= w_cur_delta + DW'(1);
                end else if (btn_down) begin
                    if (w_cur_delta != DMIN) r_delta[r_cursor] <= w_cur_delta - DW'(1);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (en && commit) begin
                        r_state <= S_SCAN;
                        r_k     <= '0;
                    end
                end
                S_SCAN: begin
                    if (r_k == KW'(NF)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_k_delta == '0) begin
                        r_k <= r_k + KW'(1);
                    end else begin
                        r_state   <= S_READ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= w_kaddr;
                    end
                end
                S_READ: begin
                    if (rd_valid) begin
                        r_rd_en   <= 1'b0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_kaddr;
                        r_wr_data <= rd_data + w_k_delta;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ack) begin
                        r_wr_en         <= 1'b0;
                        r_delta[w_kidx] <= '0;
                        r_k             <= r_k + KW'(1);
                        r_state         <= S_SCAN;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign cursor  = r_cursor;
    assign busy    = w_busy;
    assign done    = r_done;

endmodule

// File: doc/rtc_field_editor.md
RTC_FIELD_EDITOR -- requirements
Module: rtc_field_editor

Interface
REQ-001 SHALL have parameter NF, default 16: number of editable fields.
REQ-002 SHALL have parameter DW, default 8: field data width.
REQ-003 SHALL have parameter AW, default 8: register address width.
REQ-004 SHALL have parameter ADDR_MAP, default 0, width NF*AW: field i register address in bits [i*AW +: AW].
REQ-005 SHALL have port CLK  in  1  clock; all logic on the rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port en  in  1  edit enable; 0 = block idle, edits frozen.
REQ-008 SHALL have ports btn_left, btn_right, btn_up, btn_down  in  1 each  single-cycle button pulses.
REQ-009 SHALL have ports win_lo, win_hi  in  IW=clog2(NF) each  cursor window bounds, inclusive.
REQ-010 SHALL have port commit  in  1  start write-back pulse.
REQ-011 SHALL have port rd_en  out  1; rd_addr  out  AW; rd_data  in  DW; rd_valid  in  1  read handshake.
REQ-012 SHALL have port wr_en  out  1; wr_addr  out  AW; wr_data  out  DW; wr_ack  in  1  write handshake.
REQ-013 SHALL have port cursor  out  IW  current field index; busy  out  1; done  out  1  one-cycle completion pulse.

Function
REQ-014 SHALL hold one signed DW-bit delta per field; button up adds +1, down adds -1, to the field at cursor.
REQ-015 SHALL saturate each delta at +(2^(DW-1)-1) and -(2^(DW-1)-1); no wrap of delta.
REQ-016 SHALL give btn_up priority when btn_up and btn_down are asserted in the same cycle; btn_down ignored.
REQ-017 SHALL move cursor +1 on btn_right, -1 on btn_left; right priority when both asserted.
REQ-018 SHALL wrap cursor: right at win_hi goes to win_lo; left at win_lo goes to win_hi.
REQ-019 SHALL force cursor to win_lo, next cycle, when cursor is outside [win_lo, win_hi] or win_hi >= NF.
REQ-020 SHALL treat win_lo > win_hi as window {win_lo} only.
REQ-021 SHALL ignore buttons and commit when en=0; cursor and deltas retained; write-back in progress continues.
REQ-022 SHALL ignore buttons (no delta or cursor change) while busy=1.
REQ-023 SHALL implement FSM IDLE, SCAN, READ, WRITE, DONE; busy=1 in all states except IDLE.
REQ-024 IDLE: commit with en=1 -> SCAN with field index k=0.
REQ-025 SCAN: delta[k]==0 -> k+1 (skip); else -> READ; k==NF with no field left -> DONE.
REQ-026 READ: rd_en=1, rd_addr=ADDR_MAP[k], held until rd_valid; rd_data captured the same cycle; -> WRITE.
REQ-027 WRITE: wr_en=1, wr_addr=ADDR_MAP[k], wr_data=(captured+delta[k]) mod 2^DW, held stable until wr_ack.
REQ-028 WRITE on wr_ack: clear delta[k], k+1, -> SCAN; at most one field transferred per READ/WRITE pair.
REQ-029 DONE: done=1 for exactly one cycle -> IDLE.
REQ-030 SHALL ignore commit while busy=1; no queueing.
REQ-031 SHALL ignore rd_valid outside READ and wr_ack outside WRITE.
REQ-032 SHALL have latency per non-zero field >= 2 cycles plus handshake waits; SCAN costs 1 cycle per field.

Reset
REQ-033 SHALL, on reset, set cursor=0, all deltas=0, FSM=IDLE, k=0.
REQ-034 SHALL, on reset, drive rd_en=0, wr_en=0, done=0, busy=0, rd_addr=0, wr_addr=0, wr_data=0.
REQ-035 SHALL, on reset mid write-back, abort immediately, discard pending deltas, issue no further rd_en/wr_en.

Verification
REQ-036 Bench SHALL check win_lo=1, win_hi=6, cursor=6, btn_right -> cursor=1; then btn_left -> cursor=6.
REQ-037 Bench SHALL check 3x btn_up, 5x btn_down on field 2, commit, rd_data=0x10 -> single write wr_data=0x0E to ADDR_MAP[2].
REQ-038 Bench SHALL check DW=8, 200x btn_up on one field -> delta saturates at 127; rd_data=0xF0 -> wr_data=0x6F.
REQ-039 Bench SHALL check deltas non-zero on fields 0 and 5 only -> exactly two READ/WRITE pairs, in index order, then done pulse.
REQ-040 Bench SHALL check wr_ack delayed 4 cycles -> wr_en, wr_addr, wr_data stable all 4 cycles; buttons ignored meanwhile.
REQ-041 Bench SHALL check reset asserted in WRITE -> next cycle wr_en=0, busy=0, all deltas 0, no done pulse.
